// File: rtl/cpu_top_pkg.sv
// Shared RV32I encoding constants, ALU operation enum and instruction encoders
// used by both the core and its testbench.
package cpu_top_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  // alt selects SUB/SRA; callers gate it so ADDI never becomes a subtract.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD_SUB: return alt ? AluSub : AluAdd;
      F3_SLL:     return AluSll;
      F3_SLT:     return AluSlt;
      F3_SLTU:    return AluSltu;
      F3_XOR:     return AluXor;
      F3_SRL_SRA: return alt ? AluSra : AluSrl;
      F3_OR:      return AluOr;
      default:    return AluAnd;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] funct7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] funct3,
                                        input logic [4:0] rd);
    return {funct7, rs2, rs1, funct3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] funct3, input logic [4:0] rd);
    return {imm, rs1, funct3, rd, OPC_OP_IMM};
  endfunction

endpackage

// File: rtl/cpu_top_if.sv
// Control bus between the decoder in cpu_top and the data path.
interface cpu_top_if;
  import cpu_top_pkg::*;

  logic [31:0] instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  alu_op_e     alu_op;
  logic        use_imm;
  logic        reg_write;

  modport master (input instr, output rs1, rs2, rd, imm, alu_op, use_imm, reg_write);
  modport slave  (output instr, input rs1, rs2, rd, imm, alu_op, use_imm, reg_write);
endinterface

// File: rtl/cpu_top_data_path.sv
// Fetch, register file and ALU; driven by the decoded control bus.
module cpu_top_data_path
  import cpu_top_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  cpu_top_if.slave bus
);

  logic [31:0]           w_instr;
  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;
  logic [DATA_WIDTH-1:0] w_alu_b;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic [4:0]            w_shamt;

  cpu_top_ifetch instruction_fetch (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_instr   (w_instr)
  );

  assign bus.instr = w_instr;

  cpu_top_regfile #(
    .DATA_WIDTH (DATA_WIDTH)
  ) register_file (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (bus.reg_write),
    .i_waddr   (bus.rd),
    .i_wdata   (w_alu_result),
    .i_raddr1  (bus.rs1),
    .i_raddr2  (bus.rs2),
    .o_rdata1  (w_rs1_data),
    .o_rdata2  (w_rs2_data)
  );

  assign w_alu_b = bus.use_imm ? DATA_WIDTH'(bus.imm) : w_rs2_data;
  assign w_shamt = w_alu_b[4:0];

  always_comb begin
    w_alu_result = '0;
    case (bus.alu_op)
      AluAdd:  w_alu_result = w_rs1_data + w_alu_b;
      AluSub:  w_alu_result = w_rs1_data - w_alu_b;
      AluSll:  w_alu_result = w_rs1_data << w_shamt;
      AluSlt:  w_alu_result = {{(DATA_WIDTH-1){1'b0}},
                               ($signed(w_rs1_data) < $signed(w_alu_b))};
      AluSltu: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (w_rs1_data < w_alu_b)};
      AluXor:  w_alu_result = w_rs1_data ^ w_alu_b;
      AluSrl:  w_alu_result = w_rs1_data >> w_shamt;
      AluSra:  w_alu_result = $unsigned($signed(w_rs1_data) >>> w_shamt);
      AluOr:   w_alu_result = w_rs1_data | w_alu_b;
      AluAnd:  w_alu_result = w_rs1_data & w_alu_b;
      default: w_alu_result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_top_ifetch.sv
// Program counter and combinational instruction memory indexed by PC[7:0].
module cpu_top_ifetch (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic [31:0] o_instr
);

  logic [31:0] r_pc;
  // Left uninitialised: the environment loads the program before reset release.
  logic [31:0] instr_mem [0:255];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_instr = instr_mem[r_pc[7:0]];

endmodule

// File: rtl/cpu_top_regfile.sv
// 32-entry register file, two combinational reads, one synchronous write; x0 hardwired to 0.
module cpu_top_regfile #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [4:0]            i_raddr1,
  input  logic [4:0]            i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2
);

  logic [DATA_WIDTH-1:0] registers [0:31];

  // Reset seeds xi = i so programs can run without any load instructions.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= DATA_WIDTH'(i);
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      registers[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : registers[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : registers[i_raddr2];

endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV32I integer-ALU core: decoder here, datapath in data_path_inst.
module cpu_top
  import cpu_top_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic i_clk,
  input logic i_reset_n
);

  cpu_top_if ctrl_bus ();

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_f7_base;
  logic       w_f7_alt;
  alu_op_e    w_alu_op;
  logic       w_use_imm;
  logic       w_reg_write;

  assign w_opcode  = ctrl_bus.instr[6:0];
  assign w_funct3  = ctrl_bus.instr[14:12];
  assign w_funct7  = ctrl_bus.instr[31:25];
  assign w_f7_base = (w_funct7 == F7_BASE);
  assign w_f7_alt  = (w_funct7 == F7_ALT);

  // Unknown opcodes and illegal funct7 encodings fall through as NOPs.
  always_comb begin
    w_alu_op    = AluAdd;
    w_use_imm   = 1'b0;
    w_reg_write = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_reg_write = w_f7_base ||
                      (w_f7_alt && ((w_funct3 == F3_ADD_SUB) || (w_funct3 == F3_SRL_SRA)));
        w_alu_op    = alu_from_funct3(w_funct3, w_funct7[5]);
      end
      OPC_OP_IMM: begin
        w_use_imm = 1'b1;
        case (w_funct3)
          F3_SLL:     w_reg_write = w_f7_base;
          F3_SRL_SRA: w_reg_write = w_f7_base || w_f7_alt;
          default:    w_reg_write = 1'b1;
        endcase
        w_alu_op = alu_from_funct3(w_funct3, (w_funct3 == F3_SRL_SRA) && w_funct7[5]);
      end
      default: begin
      end
    endcase
  end

  assign ctrl_bus.rs1       = ctrl_bus.instr[19:15];
  assign ctrl_bus.rs2       = ctrl_bus.instr[24:20];
  assign ctrl_bus.rd        = ctrl_bus.instr[11:7];
  assign ctrl_bus.imm       = {{20{ctrl_bus.instr[31]}}, ctrl_bus.instr[31:20]};
  assign ctrl_bus.alu_op    = w_alu_op;
  assign ctrl_bus.use_imm   = w_use_imm;
  assign ctrl_bus.reg_write = w_reg_write;

  cpu_top_data_path #(
    .DATA_WIDTH (DATA_WIDTH)
  ) data_path_inst (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (ctrl_bus.slave)
  );

endmodule

// File: tb/tb_cpu_top.sv
// Directed program table plus random programs checked against an ISA-level model.
module tb_cpu_top;
  import cpu_top_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpu_top #(.DATA_WIDTH(32)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n)
  );

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] exp_regs [32];
  logic [31:0] prog [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] dut_reg(input int i);
    return dut.data_path_inst.register_file.registers[i];
  endfunction

  function automatic logic [31:0] dut_pc();
    return dut.data_path_inst.instruction_fetch.r_pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One aggregate comparison of the whole register file against a reference array.
  task automatic check_regs(input string name, input logic [31:0] ref_regs [32]);
    int bad;
    bad = -1;
    for (int i = 31; i >= 0; i--) if (dut_reg(i) !== ref_regs[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: x%0d got %h expected %h", name, bad, dut_reg(bad), ref_regs[bad]);
    end
  endtask

  task automatic load_mem(input logic [31:0] words [256]);
    for (int i = 0; i < 256; i++) dut.data_path_inst.instruction_fetch.instr_mem[i] = words[i];
  endtask

  // ISA-level reference: executes one instruction on m_regs/m_pc.
  task automatic model_step();
    logic [31:0] ins, a, b, imm, res;
    logic [9:0]  f73;
    logic        ok;
    ins = prog[m_pc[7:0]];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    f73 = {ins[31:25], ins[14:12]};
    ok  = 1'b1;
    res = '0;
    if (ins[6:0] == 7'b0110011) begin
      case (f73)
        10'b0000000_000: res = a + b;
        10'b0100000_000: res = a - b;
        10'b0000000_001: res = a << b[4:0];
        10'b0000000_010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        10'b0000000_011: res = (a < b) ? 32'd1 : 32'd0;
        10'b0000000_100: res = a ^ b;
        10'b0000000_101: res = a >> b[4:0];
        10'b0100000_101: res = $unsigned($signed(a) >>> b[4:0]);
        10'b0000000_110: res = a | b;
        10'b0000000_111: res = a & b;
        default:         ok = 1'b0;
      endcase
    end else if (ins[6:0] == 7'b0010011) begin
      case (ins[14:12])
        3'b000:  res = a + imm;
        3'b010:  res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'b011:  res = (a < imm) ? 32'd1 : 32'd0;
        3'b100:  res = a ^ imm;
        3'b110:  res = a | imm;
        3'b111:  res = a & imm;
        3'b001:  begin ok = (ins[31:25] == 7'd0); res = a << ins[24:20]; end
        default: begin
          ok  = (ins[31:25] == 7'd0) || (ins[31:25] == 7'h20);
          res = ins[30] ? $unsigned($signed(a) >>> ins[24:20]) : a >> ins[24:20];
        end
      endcase
    end else begin
      ok = 1'b0;
    end
    if (ok && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = m_pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rd, rs1, rs2;
    int          k;
    w   = $urandom();
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    k   = $urandom_range(0, 19);
    case (k)
      0:  return enc_r(F7_BASE, rs2, rs1, F3_ADD_SUB, rd);
      1:  return enc_r(F7_ALT,  rs2, rs1, F3_ADD_SUB, rd);
      2:  return enc_r(F7_BASE, rs2, rs1, F3_SLL,     rd);
      3:  return enc_r(F7_BASE, rs2, rs1, F3_SLT,     rd);
      4:  return enc_r(F7_BASE, rs2, rs1, F3_SLTU,    rd);
      5:  return enc_r(F7_BASE, rs2, rs1, F3_XOR,     rd);
      6:  return enc_r(F7_BASE, rs2, rs1, F3_SRL_SRA, rd);
      7:  return enc_r(F7_ALT,  rs2, rs1, F3_SRL_SRA, rd);
      8:  return enc_r(F7_BASE, rs2, rs1, F3_OR,      rd);
      9:  return enc_r(F7_BASE, rs2, rs1, F3_AND,     rd);
      10: return enc_i(w[31:20], rs1, F3_ADD_SUB, rd);
      11: return enc_i(w[31:20], rs1, F3_SLT,     rd);
      12: return enc_i(w[31:20], rs1, F3_SLTU,    rd);
      13: return enc_i(w[31:20], rs1, F3_XOR,     rd);
      14: return enc_i(w[31:20], rs1, F3_OR,      rd);
      15: return enc_i(w[31:20], rs1, F3_AND,     rd);
      16: return enc_i({F7_BASE, rs2}, rs1, F3_SLL,     rd);
      17: return enc_i({F7_BASE, rs2}, rs1, F3_SRL_SRA, rd);
      18: return enc_i({F7_ALT,  rs2}, rs1, F3_SRL_SRA, rd);
      default: begin
        w[6:0] = 7'b0000011;
        return w;
      end
    endcase
  endfunction

  initial begin
    vecs[0]  = '{enc_r(F7_BASE, 5'd1, 5'd0, F3_ADD_SUB, 5'd2), 2, 32'd1, "add_x2"};
    vecs[1]  = '{enc_r(F7_BASE, 5'd3, 5'd1, F3_ADD_SUB, 5'd4), 4, 32'd4, "add_x4"};
    vecs[2]  = '{enc_r(F7_ALT,  5'd1, 5'd5, F3_ADD_SUB, 5'd5), 5, 32'd4, "sub_x5"};
    vecs[3]  = '{enc_r(F7_BASE, 5'd8, 5'd7, F3_OR,      5'd6), 6, 32'd15, "or_x6"};
    vecs[4]  = '{enc_r(F7_BASE, 5'd2, 5'd4, F3_AND,     5'd4), 4, 32'd0, "and_x4"};
    vecs[5]  = '{enc_r(F7_BASE, 5'd2, 5'd3, F3_XOR,     5'd5), 5, 32'd2, "xor_x5"};
    vecs[6]  = '{enc_r(F7_BASE, 5'd2, 5'd6, F3_SLL,     5'd2), 2, 32'd30, "sll_x2"};
    vecs[7]  = '{enc_r(F7_BASE, 5'd3, 5'd1, F3_ADD_SUB, 5'd0), 0, 32'd0, "add_x0"};
    vecs[8]  = '{enc_i(12'hFF0, 5'd0, F3_ADD_SUB, 5'd31), 31, 32'hFFFF_FFF0, "addi_x31"};
    vecs[9]  = '{enc_i({F7_ALT, 5'd2}, 5'd31, F3_SRL_SRA, 5'd9), 9, 32'hFFFF_FFFC, "srai_x9"};
    vecs[10] = '{enc_i({F7_BASE, 5'd28}, 5'd31, F3_SRL_SRA, 5'd10), 10, 32'h0000_000F,
                 "srli_x10"};
    vecs[11] = '{enc_r(F7_BASE, 5'd1, 5'd31, F3_SLT,  5'd11), 11, 32'd1, "slt_x11"};
    vecs[12] = '{enc_r(F7_BASE, 5'd1, 5'd31, F3_SLTU, 5'd12), 12, 32'd0, "sltu_x12"};
    vecs[13] = '{enc_r(F7_ALT,  5'd2, 5'd31, F3_SRL_SRA, 5'd13), 13, 32'hFFFF_FFFF, "sra_x13"};

    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    for (int k = 0; k < 14; k++) prog[4 * k] = vecs[k].instr;
    prog[64] = 32'hFFFF_FFFF;  // opcode 1111111: must behave as a NOP
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'(i);

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    load_mem(prog);
    repeat (2) @(negedge clk);
    check("reset_pc", dut_pc(), 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut_reg(i), 32'(i));

    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      check(vecs[k].name, dut_reg(vecs[k].rd), vecs[k].exp);
      check($sformatf("pc_after_%0d", k), dut_pc(), 32'(4 * (k + 1)));
      if (vecs[k].rd != 0) exp_regs[vecs[k].rd] = vecs[k].exp;
    end

    // Words 14..16: two zero words and one all-ones word, all NOPs.
    repeat (3) @(negedge clk);
    check("nop_pc", dut_pc(), 32'd68);
    check_regs("nop_regs", exp_regs);

    // Asynchronous reset mid-program, sampled before any clock edge.
    rst_n = 1'b0;
    #1;
    check("async_reset_pc", dut_pc(), 32'd0);
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'(i);
    check_regs("async_reset_regs", exp_regs);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_x2", dut_reg(2), 32'd1);
    check("restart_pc", dut_pc(), 32'd4);

    // Random programs filling every populated slot; run past the PC[7:0] wrap.
    for (int trial = 0; trial < 3; trial++) begin
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = (i % 4 == 0) ? rand_instr() : 32'd0;
      load_mem(prog);
      for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
      m_pc = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 150; c++) begin
        model_step();
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rand%0d_pc_c%0d", trial, c), dut_pc(), m_pc);
        check_regs($sformatf("rand%0d_regs_c%0d", trial, c), m_regs);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath/register width; only 32 is supported.
REQ-002 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 No other ports. State is observable only hierarchically (REQ-021, REQ-022).

Function
REQ-005 The core SHALL be single-cycle RV32I: fetch, decode, execute and writeback of one instruction per i_clk cycle.
REQ-006 Supported R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, decoded per RV32I funct3/funct7.
REQ-007 Supported I-type ALU (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; immediate sign-extended from bits 31:20.
REQ-008 Shifts SHALL use rs2/shamt bits 4:0 only; SRA/SRAI are arithmetic, SRL/SRLI logical.
REQ-009 SLT/SLTI compare signed, SLTU/SLTIU unsigned; result is 1 or 0.
REQ-010 Arithmetic SHALL wrap modulo 2^32; no overflow detection.
REQ-011 Any other opcode, including 0x00000000 and X, SHALL act as a NOP: no register write, PC advances by 4.
REQ-012 Register file: 32 x 32 bits, two combinational read ports, one write port written on rising edge when the instruction is valid.
REQ-013 x0 SHALL read 0 always; writes to x0 are discarded.
REQ-014 Read during a write to the same register SHALL return the old value; the new value is visible next cycle.
REQ-015 PC SHALL be 32 bits and advance by 4 on every rising edge while not in reset; no branches or jumps.
REQ-016 Instruction memory: 256 words of 32 bits, indexed directly by PC[7:0] (byte address used as index; only multiples of 4 are populated); read is combinational.
REQ-017 PC past 252 SHALL wrap through PC[7:0] back to index 0.
REQ-018 Instruction memory SHALL have no reset and no RTL initialisation; contents are loaded by the bench at time 0.

Reset
REQ-019 While i_reset_n=0: PC=0, register xi = i for i=1..31, x0=0, and no register writes occur.
REQ-020 Reset assertion mid-execution SHALL take effect immediately (asynchronously); after deassertion, the instruction at index 0 executes and writes back on the first rising edge.

Structure
REQ-021 cpu_top SHALL contain one data_path instance named data_path_inst, which contains an instance named instruction_fetch holding the array instr_mem[0:255].
REQ-022 The register file array SHALL be reachable as data_path_inst.register_file.registers[0:31].
REQ-023 Decode (control) logic may live directly in cpu_top; data_path is the one natural sub-module.
REQ-024 A shared package SHALL hold the opcode, funct3 and funct7 constants and the ALU-operation enum; the bench encoder package uses the same constants.

Verification
REQ-025 Program add x2,x0,x1; add x4,x1,x3; sub x5,x5,x1, then release reset -> after edges 1/2/3: x2=1, x4=4, x5=4.
REQ-026 Continue with or x6,x7,x8; and x4,x4,x2; xor x5,x3,x2; sll x2,x6,x2 -> x6=15, x4=0, x5=2, x2=30.
REQ-027 add x0,x1,x3 -> x0 remains 0; unpopulated words (0 or X) -> no register changes and PC+4 each cycle.
REQ-028 sra x9,x31... with x31 preloaded via addi x31,x0,-16, then srai x9,x31,2 -> x9=0xFFFFFFFC; srli x10,x31,28 -> x10=0xF.
REQ-029 slt x11,x31,x1 -> 1; sltu x12,x31,x1 -> 0.
REQ-030 Assert i_reset_n=0 mid-program -> PC=0 and xi=i immediately, without a clock edge; after release, the program restarts at index 0.
